// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 2-write / 2-read register file.
package reg_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  // Source that feeds an entry's next value, listed from highest to lowest priority.
  typedef enum logic [1:0] {
    SRC_WRITE_A = 2'd3,
    SRC_WRITE_B = 2'd2,
    SRC_SP_STEP = 2'd1,
    SRC_HOLD    = 2'd0
  } wr_src_e;

  // Picks the winning source for one entry: port A beats port B beats the SP step.
  function automatic wr_src_e pick_src(input logic hit_a, input logic hit_b,
                                       input logic hit_sp);
    if (hit_a)       return SRC_WRITE_A;
    else if (hit_b)  return SRC_WRITE_B;
    else if (hit_sp) return SRC_SP_STEP;
    else             return SRC_HOLD;
  endfunction

endpackage

// File: rtl/reg_file_wr_arb.sv
// Combinational write arbitration: computes every entry's next value and
// enable, plus the same-address conflict and stack-pointer wrap flags.
module reg_file_wr_arb
  import reg_file_pkg::*;
#(
  parameter int              DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int              ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit              ZERO_REG   = 1'b0,
  parameter int              SP_INDEX   = (2 ** ADDR_WIDTH) - 1,
  localparam int             DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] cur_q [DEPTH],
  input  logic [DATA_WIDTH-1:0] Data_in_A,
  input  logic [ADDR_WIDTH-1:0] Write_address_A,
  input  logic                  Write_enable_A,
  input  logic [DATA_WIDTH-1:0] Data_in_B,
  input  logic [ADDR_WIDTH-1:0] Write_address_B,
  input  logic                  Write_enable_B,
  input  logic                  SP_inc,
  input  logic                  SP_dec,
  output logic [DATA_WIDTH-1:0] next_d [DEPTH],
  output logic                  entry_we [DEPTH],
  output logic                  conflict,
  output logic                  sp_wrap
);

  localparam logic [ADDR_WIDTH-1:0] SP_ADDR = ADDR_WIDTH'(SP_INDEX);

  logic [DATA_WIDTH-1:0] sp_cur;
  logic [DATA_WIDTH-1:0] sp_stepped;
  logic                  sp_blocked;
  logic                  sp_step;
  wr_src_e               src [DEPTH];

  // Stack-pointer step: one direction only, suppressed when a write port owns the entry.
  always_comb begin
    sp_cur     = cur_q[SP_INDEX];
    sp_blocked = (Write_enable_A && (Write_address_A == SP_ADDR)) ||
                 (Write_enable_B && (Write_address_B == SP_ADDR));
    sp_step    = (SP_inc ^ SP_dec) && !sp_blocked;
    sp_stepped = SP_inc ? (sp_cur + DATA_WIDTH'(1)) : (sp_cur - DATA_WIDTH'(1));
    sp_wrap    = 1'b0;
    if (sp_step) begin
      if (SP_inc) sp_wrap = (sp_cur == {DATA_WIDTH{1'b1}});
      else        sp_wrap = (sp_cur == {DATA_WIDTH{1'b0}});
    end
  end

  // Conflict is raised even for the discarded zero entry, since both ports still collided.
  always_comb begin
    conflict = Write_enable_A && Write_enable_B && (Write_address_A == Write_address_B);
  end

  // Per-entry source selection and next-value mux.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src[i]      = SRC_HOLD;
      next_d[i]   = cur_q[i];
      entry_we[i] = 1'b0;
      if (ZERO_REG && (i == 0)) begin
        next_d[i] = '0;
      end else begin
        src[i] = pick_src(Write_enable_A && (Write_address_A == ADDR_WIDTH'(i)),
                          Write_enable_B && (Write_address_B == ADDR_WIDTH'(i)),
                          sp_step && (i == SP_INDEX));
        case (src[i])
          SRC_WRITE_A: next_d[i] = Data_in_A;
          SRC_WRITE_B: next_d[i] = Data_in_B;
          SRC_SP_STEP: next_d[i] = sp_stepped;
          default:     next_d[i] = cur_q[i];
        endcase
        entry_we[i] = (src[i] != SRC_HOLD);
      end
    end
  end

endmodule

// File: rtl/reg_file_2w2r.sv
// Register file with two write ports, two registered read ports with
// write-through bypass, optional hardwired-zero entry and an inc/dec
// stack-pointer entry. Holds storage, read registers and flag pulses.
module reg_file_2w2r
  import reg_file_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter bit                    ZERO_REG    = 1'b0,
  parameter int                    SP_INDEX    = (2 ** ADDR_WIDTH) - 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_in_A,
  input  logic [ADDR_WIDTH-1:0] Write_address_A,
  input  logic                  Write_enable_A,
  input  logic [DATA_WIDTH-1:0] Data_in_B,
  input  logic [ADDR_WIDTH-1:0] Write_address_B,
  input  logic                  Write_enable_B,
  input  logic [ADDR_WIDTH-1:0] Read_address_A,
  input  logic [ADDR_WIDTH-1:0] Read_address_B,
  input  logic                  SP_inc,
  input  logic                  SP_dec,
  output logic [DATA_WIDTH-1:0] Out_A,
  output logic [DATA_WIDTH-1:0] Out_B,
  output logic [DATA_WIDTH-1:0] SP_out,
  output logic                  Write_conflict,
  output logic                  SP_wrap
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem    [DEPTH];
  logic [DATA_WIDTH-1:0] next_d [DEPTH];
  logic                  entry_we [DEPTH];
  logic                  conflict;
  logic                  sp_wrap;

  reg_file_wr_arb #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG),
    .SP_INDEX   (SP_INDEX)
  ) u_wr_arb (
    .cur_q           (mem),
    .Data_in_A       (Data_in_A),
    .Write_address_A (Write_address_A),
    .Write_enable_A  (Write_enable_A),
    .Data_in_B       (Data_in_B),
    .Write_address_B (Write_address_B),
    .Write_enable_B  (Write_enable_B),
    .SP_inc          (SP_inc),
    .SP_dec          (SP_dec),
    .next_d          (next_d),
    .entry_we        (entry_we),
    .conflict        (conflict),
    .sp_wrap         (sp_wrap)
  );

  // Storage update; reset wins over any write or SP step in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;
      end else if (entry_we[i]) begin
        mem[i] <= next_d[i];
      end
    end
  end

  // Read registers sample the next-state values so same-edge updates bypass through.
  always_ff @(posedge clk) begin
    if (rst) begin
      Out_A <= '0;
      Out_B <= '0;
    end else begin
      Out_A <= next_d[Read_address_A];
      Out_B <= next_d[Read_address_B];
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      Write_conflict <= 1'b0;
      SP_wrap        <= 1'b0;
    end else begin
      Write_conflict <= conflict;
      SP_wrap        <= sp_wrap;
    end
  end

  // Stack pointer is read straight from storage, without bypass.
  always_comb begin
    SP_out = mem[SP_INDEX];
  end

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed bench for reg_file_2w2r: one instance without and one with the
// hardwired-zero entry, driven by the same stimulus.
module tb_reg_file_2w2r;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic [1:0] wa_a, wa_b, ra_a, ra_b;
  logic       we_a, we_b, sp_inc, sp_dec;

  logic [7:0] out_a0, out_b0, sp0, out_a1, out_b1, sp1;
  logic       conf0, wrap0, conf1, wrap1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_file_2w2r #(.ZERO_REG(1'b0), .RESET_VALUE(8'h5A)) u_dut0 (
    .clk(clk), .rst(rst),
    .Data_in_A(din_a), .Write_address_A(wa_a), .Write_enable_A(we_a),
    .Data_in_B(din_b), .Write_address_B(wa_b), .Write_enable_B(we_b),
    .Read_address_A(ra_a), .Read_address_B(ra_b),
    .SP_inc(sp_inc), .SP_dec(sp_dec),
    .Out_A(out_a0), .Out_B(out_b0), .SP_out(sp0),
    .Write_conflict(conf0), .SP_wrap(wrap0)
  );

  reg_file_2w2r #(.ZERO_REG(1'b1), .RESET_VALUE(8'h5A)) u_dut1 (
    .clk(clk), .rst(rst),
    .Data_in_A(din_a), .Write_address_A(wa_a), .Write_enable_A(we_a),
    .Data_in_B(din_b), .Write_address_B(wa_b), .Write_enable_B(we_b),
    .Read_address_A(ra_a), .Read_address_B(ra_b),
    .SP_inc(sp_inc), .SP_dec(sp_dec),
    .Out_A(out_a1), .Out_B(out_b1), .SP_out(sp1),
    .Write_conflict(conf1), .SP_wrap(wrap1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; sp_inc = 0; sp_dec = 0; rst = 0;
  endtask

  initial begin
    idle();
    din_a = 0; din_b = 0; wa_a = 0; wa_b = 0; ra_a = 0; ra_b = 0;

    // dirty the storage before reset
    we_a = 1; wa_a = 0; din_a = 8'h01; we_b = 1; wa_b = 1; din_b = 8'h02;
    step();
    wa_a = 2; din_a = 8'h03; wa_b = 3; din_b = 8'h04;
    step();

    // reset with a write and SP step pending: both lost
    rst = 1; we_a = 1; wa_a = 1; din_a = 8'hFF; we_b = 0; sp_inc = 1;
    step();
    check("rst_out_a", out_a0, 8'h00);
    check("rst_out_b", out_b0, 8'h00);
    check("rst_conf", {7'b0, conf0}, 8'h00);
    check("rst_wrap", {7'b0, wrap0}, 8'h00);
    check("rst_sp0", sp0, 8'h5A);
    check("rst_sp1", sp1, 8'h5A);

    idle(); ra_a = 1; ra_b = 2;
    step();
    check("rst_e1", out_a0, 8'h5A);
    check("rst_e2", out_b0, 8'h5A);
    ra_a = 0; ra_b = 3;
    step();
    check("rst_e0", out_a0, 8'h5A);
    check("rst_e3", out_b0, 8'h5A);
    check("zero_e0_rst", out_a1, 8'h00);

    // write-through bypass
    we_a = 1; wa_a = 1; din_a = 8'h3C; ra_a = 1; ra_b = 2;
    step();
    check("bypass_a", out_a0, 8'h3C);
    check("bypass_b", out_b0, 8'h5A);

    // same-address conflict: A wins
    we_a = 1; wa_a = 2; din_a = 8'h11; we_b = 1; wa_b = 2; din_b = 8'h22; ra_a = 2;
    step();
    check("conf_data", out_a0, 8'h11);
    check("conf_pulse", {7'b0, conf0}, 8'h01);
    idle(); ra_b = 2;
    step();
    check("conf_clear", {7'b0, conf0}, 8'h00);
    check("conf_stored", out_b0, 8'h11);

    // different addresses: both stored
    we_a = 1; wa_a = 0; din_a = 8'h77; we_b = 1; wa_b = 1; din_b = 8'h88; ra_a = 0; ra_b = 1;
    step();
    check("dual_a", out_a0, 8'h77);
    check("dual_b", out_b0, 8'h88);
    check("dual_noconf", {7'b0, conf0}, 8'h00);
    check("zero_dual", out_a1, 8'h00);
    check("zero_dual_b", out_b1, 8'h88);

    // SP increment wrap
    idle(); we_a = 1; wa_a = 3; din_a = 8'hFF; ra_a = 3;
    step();
    check("sp_load", sp0, 8'hFF);
    idle(); sp_inc = 1; ra_b = 3;
    step();
    check("sp_inc_wrap", sp0, 8'h00);
    check("sp_wrap_pulse", {7'b0, wrap0}, 8'h01);
    check("sp_bypass", out_b0, 8'h00);
    sp_inc = 1; sp_dec = 1;
    step();
    check("sp_both", sp0, 8'h00);
    check("sp_both_nowrap", {7'b0, wrap0}, 8'h00);
    sp_inc = 0; sp_dec = 1;
    step();
    check("sp_dec_wrap", sp0, 8'hFF);
    check("sp_dec_pulse", {7'b0, wrap0}, 8'h01);
    step();
    check("sp_dec", sp0, 8'hFE);
    check("sp_dec_nowrap", {7'b0, wrap0}, 8'h00);

    // write port on SP overrides the decrement
    sp_dec = 1; we_b = 1; wa_b = 3; din_b = 8'h40;
    step();
    check("sp_wr_override", sp0, 8'h40);
    check("sp_wr_nowrap", {7'b0, wrap0}, 8'h00);
    check("sp_wr_override1", sp1, 8'h40);

    // hardwired zero entry
    idle(); we_a = 1; wa_a = 0; din_a = 8'hAA; ra_a = 0;
    step();
    check("zero_wr", out_a1, 8'h00);
    check("nonzero_wr", out_a0, 8'hAA);
    we_a = 1; wa_a = 0; we_b = 1; wa_b = 0; din_b = 8'h55;
    step();
    check("zero_conf", {7'b0, conf1}, 8'h01);
    check("zero_conf_data", out_a1, 8'h00);

    // reset in the middle of SP increments
    idle(); sp_inc = 1;
    step();
    check("sp_run1", sp1, 8'h41);
    step();
    check("sp_run2", sp1, 8'h42);
    rst = 1;
    step();
    check("sp_run_rst", sp1, 8'h5A);
    rst = 0;
    step();
    check("sp_run_after", sp1, 8'h5B);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_2w2r.md
# reg_file_2w2r

Parametrised register file for the 8-bit CPU datapath: two write ports, two registered read ports with write-through bypass, an optional hardwired-zero entry, and a built-in increment/decrement port on a designated stack-pointer entry. It sits between the writeback stage and the ALU operand latches. It supersedes the fixed 4×8, write-only-storage register file.

## Interface
- DATA_WIDTH, 8, bits per entry
- ADDR_WIDTH, 2, address bits; DEPTH = 2**ADDR_WIDTH entries
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes/inc/dec
- SP_INDEX, DEPTH-1, entry controlled by SP_inc/SP_dec; must be < DEPTH and ≠ 0 when ZERO_REG=1
- RESET_VALUE, 0, value loaded into every entry on reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- Data_in_A  in  DATA_WIDTH  write data, port A
- Write_address_A  in  ADDR_WIDTH  write address, port A
- Write_enable_A  in  1  write strobe, port A
- Data_in_B  in  DATA_WIDTH  write data, port B
- Write_address_B  in  ADDR_WIDTH  write address, port B
- Write_enable_B  in  1  write strobe, port B
- Read_address_A  in  ADDR_WIDTH  read address, output A
- Read_address_B  in  ADDR_WIDTH  read address, output B
- SP_inc  in  1  increment entry SP_INDEX
- SP_dec  in  1  decrement entry SP_INDEX
- Out_A  out  DATA_WIDTH  registered read data A
- Out_B  out  DATA_WIDTH  registered read data B
- SP_out  out  DATA_WIDTH  current SP_INDEX contents (direct from storage)
- Write_conflict  out  1  registered pulse: both ports wrote the same address
- SP_wrap  out  1  registered pulse: SP wrapped

## Operation
- Reset (rst=1 at edge): all entries ← RESET_VALUE (entry 0 reads 0 if ZERO_REG); Out_A, Out_B, Write_conflict, SP_wrap ← 0. Reset overrides every write/inc/dec in that cycle.
- Per-entry next value priority: port A write > port B write > SP inc/dec > hold.
- Same-address writes from A and B: A's data stored, B dropped, Write_conflict=1 next cycle. Different addresses: both stored.
- SP: SP_inc XOR SP_dec selects ±1, modulo 2^DATA_WIDTH; both or neither asserted → no change. Ignored when either write port targets SP_INDEX in that cycle.
- SP_wrap=1 next cycle only if inc/dec was actually applied and moved 0xFF→0x00 (inc) or 0x00→0xFF (dec) (DATA_WIDTH=8).
- Reads: Out_X ← next-state value of entry Read_address_X (write-through bypass covering writes and inc/dec). Address 0 with ZERO_REG=1 → 0.
- Writes to address 0 with ZERO_REG=1 are discarded, but still raise Write_conflict if both ports target it.

## Timing
- Read latency 1 cycle: address at edge n → data on Out_X after edge n, including data written at edge n.
- SP_out reflects storage, so it changes right after the updating edge, with no bypass.
- Write_conflict and SP_wrap are 1-cycle pulses. They are asserted the cycle after the causing edge and are 0 otherwise.
- No stalls or back-pressure: every input is sampled on every edge.

## Structure
- Package reg_file_pkg: default DATA_WIDTH/ADDR_WIDTH constants, port-priority encoding constants.
- Sub-module reg_file_wr_arb (combinational): per-entry next value, write-enable, conflict and wrap detection. The top level holds storage, read registers and pulse flops.

## Test plan
- Reset with entries dirty, RESET_VALUE=8'h5A → after one edge all reads return 8'h5A, Out_A=Out_B=0 during reset, both flags 0.
- Write_A addr 1 = 8'h3C with Read_address_A=1 in the same cycle → Out_A=8'h3C after that edge (bypass).
- Both ports write addr 2 (A=8'h11, B=8'h22) → entry 2=8'h11, Write_conflict=1 for exactly one cycle.
- SP=8'hFF, SP_inc=1 → SP_out=8'h00, SP_wrap pulses. Then SP_inc=SP_dec=1 → SP unchanged, no pulse.
- SP_dec=1 while Write_B targets SP_INDEX with 8'h40 → SP=8'h40, no decrement, no wrap.
- ZERO_REG=1: write 8'hAA to addr 0, read addr 0 → Out_A=8'h00; rst asserted mid-sequence of SP_inc pulses → SP=RESET_VALUE, increments in the reset cycle lost.
